// File: rtl/bank64_pkg.sv
// bank64_pkg: shared sizes and scan state encoding for the 64-entry bank scanner.
package bank64_pkg;
    localparam int NREG  = 64;
    localparam int SEL_W = 6;
    localparam int CNT_W = 7;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
endpackage

// File: rtl/bank64_scan_if.sv
// bank64_scan_if: write port, scan control and selector-facing bus of the bank scanner.
interface bank64_scan_if #(parameter int size = 64);
    import bank64_pkg::*;
    logic                   we;
    logic [SEL_W-1:0]       wa;
    logic [size-1:0]        wd;
    logic                   start;
    logic [SEL_W-1:0]       base;
    logic [CNT_W-1:0]       count;
    logic                   out_ready;
    logic [NREG*size-1:0]   regs_flat;
    logic [SEL_W-1:0]       sel;
    logic                   out_valid;
    logic                   busy;
    logic                   done;
    modport master (output we, wa, wd, start, base, count, out_ready,
                    input  regs_flat, sel, out_valid, busy, done);
    modport slave  (input  we, wa, wd, start, base, count, out_ready,
                    output regs_flat, sel, out_valid, busy, done);
endinterface

// File: rtl/regbank64.sv
// regbank64: 64 x size register bank with one write port and a flat output of all entries.
module regbank64 import bank64_pkg::*; #(parameter int size = 64) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [SEL_W-1:0]     wa,
    input  logic [size-1:0]      wd,
    output logic [NREG*size-1:0] regs_flat
);
    logic [size-1:0] mem [NREG];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end
    genvar i;
    for (i = 0; i < NREG; i++) begin : g_flat
        assign regs_flat[i*size +: size] = mem[i];
    end
endmodule

// File: rtl/bank64_scan.sv
// bank64_scan: register bank plus a scan engine that walks the selector index under valid/ready.
module bank64_scan import bank64_pkg::*; #(parameter int size = 64) (
    input  logic         clk,
    input  logic         reset,
    bank64_scan_if.slave bus
);
    scan_state_t      state, state_n;
    logic [SEL_W-1:0] sel, sel_n;
    logic [CNT_W-1:0] remaining, remaining_n, count_sat;
    regbank64 #(.size(size)) u_bank (
        .clk       (clk),
        .reset     (reset),
        .we        (bus.we),
        .wa        (bus.wa),
        .wd        (bus.wd),
        .regs_flat (bus.regs_flat)
    );
    // Illegal counts above 64 clamp to one full pass of the bank.
    assign count_sat = (bus.count > CNT_W'(NREG)) ? CNT_W'(NREG) : bus.count;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sel       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            remaining <= remaining_n;
        end
    end
    always_comb begin
        state_n     = state;
        sel_n       = sel;
        remaining_n = remaining;
        case (state)
            IDLE: if (bus.start) begin
                state_n = (bus.count == '0) ? DONE : SCAN;
                if (bus.count != '0) begin
                    sel_n       = bus.base;
                    remaining_n = count_sat;
                end
            end
            SCAN: if (bus.out_ready) begin
                sel_n       = sel + SEL_W'(1);
                remaining_n = remaining - CNT_W'(1);
                state_n     = (remaining == CNT_W'(1)) ? DONE : SCAN;
            end
            default: state_n = IDLE;
        endcase
    end
    assign bus.sel       = sel;
    assign bus.out_valid = (state == SCAN);
    assign bus.busy      = (state == SCAN);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_bank64_scan.sv
// tb_bank64_scan: scoreboard bench; expected select indices queued at start, checked on each handshake.
module tb_bank64_scan;
    logic clk = 0;
    logic reset = 1;
    int total = 0;
    int bad = 0;
    int vcnt = 0;
    logic [5:0]  q [$];
    logic [63:0] model [64];
    bank64_scan_if #(.size(64)) bus ();
    bank64_scan #(.size(64)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Stalled cycles must hold the pending index; transfers pop it and check the word seen.
    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            vcnt++;
            if (q.size() == 0) chk("q_underflow", 1, 0);
            else begin
                chk("sel", bus.sel, q[0]);
                if (bus.out_ready) begin
                    chk("data", bus.regs_flat[bus.sel*64 +: 64], model[q[0]]);
                    void'(q.pop_front());
                end
            end
        end
    end
    task automatic wr(input logic [5:0] a, input logic [63:0] d);
        bus.we = 1; bus.wa = a; bus.wd = d;
        @(posedge clk); #1;
        bus.we = 0;
        model[a] = d;
    endtask
    task automatic scan(input logic [5:0] b, input logic [6:0] c, input logic [127:0] rdy,
                        input int exp_cyc, input int exp_val, input bit noise,
                        input int wk, input logic [5:0] wad, input logic [63:0] wdat);
        int n;
        int k;
        bit got;
        n = (c > 64) ? 64 : int'(c);
        k = 0;
        got = 0;
        for (int i = 0; i < n; i++) q.push_back(b + 6'(i));
        vcnt = 0;
        bus.start = 1; bus.base = b; bus.count = c; bus.out_ready = rdy[0];
        while (!got && k < 200) begin
            @(posedge clk); #1;
            k++;
            bus.start = noise & k[0];
            bus.out_ready = rdy[k[6:0]];
            if (bus.we) begin
                bus.we = 0;
                model[wad] = wdat;
                chk("wr_slice", bus.regs_flat[wad*64 +: 64], wdat);
                chk("wr_sel_hold", bus.sel, wad);
            end
            if (k == wk) begin
                bus.we = 1; bus.wa = wad; bus.wd = wdat;
            end
            if (bus.done) got = 1;
        end
        bus.start = 0;
        bus.out_ready = 1;
        chk("done_cycle", k, exp_cyc);
        chk("valid_cycles", vcnt, exp_val);
        chk("q_drained", q.size(), 0);
        @(posedge clk); #1;
        chk("done_once", bus.done, 0);
        chk("idle_after", bus.busy | bus.out_valid, 0);
    endtask
    initial begin
        bus.we = 0; bus.wa = 0; bus.wd = 0; bus.start = 0;
        bus.base = 0; bus.count = 0; bus.out_ready = 1;
        for (int i = 0; i < 64; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", bus.sel, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flat", |bus.regs_flat, 0);
        reset = 0;
        for (int i = 0; i < 64; i++) wr(6'(i), 64'(i + 100));
        chk("flat_0", bus.regs_flat[63:0], 100);
        chk("flat_63", bus.regs_flat[63*64 +: 64], 163);
        scan(6'd0, 7'd64, ~128'h0, 65, 64, 0, -1, 0, 0);
        scan(6'd62, 7'd4, ~128'h0, 5, 4, 0, -1, 0, 0);
        scan(6'd5, 7'd3, ~128'h0C, 6, 5, 1, -1, 0, 0);
        scan(6'd9, 7'd0, ~128'h0, 1, 0, 1, -1, 0, 0);
        scan(6'd8, 7'd5, ~128'h18, 8, 7, 0, 3, 6'd10, 64'hDEAD);
        scan(6'd17, 7'd100, ~128'h0, 65, 64, 0, -1, 0, 0);
        for (int i = 0; i < 20; i++) q.push_back(6'(i));
        bus.start = 1; bus.base = 0; bus.count = 20; bus.out_ready = 1;
        @(posedge clk); #1;
        bus.start = 0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_sel", bus.sel, 7);
        reset = 1;
        @(posedge clk); #1;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_sel", bus.sel, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_flat", |bus.regs_flat, 0);
        reset = 0;
        q.delete();
        for (int i = 0; i < 64; i++) model[i] = '0;
        @(posedge clk); #1;
        chk("abort_no_done", bus.done, 0);
        wr(6'd41, 64'h1234_5678_9ABC_DEF0);
        scan(6'd40, 7'd3, ~128'h0, 4, 3, 0, -1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bank64_scan.md
Name: bank64_scan

Overview:
- Upstream feeder of the 64:1 word selector: holds a 64-entry bank of `size`-bit registers and drives both the selector's data inputs and its 6-bit select.
- Write port: random-access writes.
- Scan engine: walks the select from a base index for a programmable count, with wrap-around.
- Each selected word is presented downstream under a valid/ready handshake; a done pulse marks the end of a run.

Parameters:
- size, 64, width of each bank entry and of wd/regs_flat slices.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- we  in  1  write enable for the bank
- wa  in  6  write address
- wd  in  size  write data
- start  in  1  request a scan; accepted only in IDLE
- base  in  6  first index of the scan, sampled with accepted start
- count  in  7  number of words to scan, 0..64, sampled with accepted start
- out_ready  in  1  downstream accepts the current word
- regs_flat  out  64*size  bank contents, entry i at bits [i*size +: size], drives selector d0..d63
- sel  out  6  index driven to the selector's s input
- out_valid  out  1  sel points at a word to be consumed this cycle
- busy  out  1  high in SCAN
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Clock/reset: one clock `clk`; reset is synchronous and active-high, named `reset`.
- On reset: all 64 entries = 0, sel = 0, out_valid = 0, busy = 0, done = 0, state = IDLE, remaining = 0.
- Write port: if we is high at an edge, entry[wa] <= wd.
  - Writes are allowed in every state, including during SCAN and in the reset cycle; reset wins.
  - regs_flat shows the new value from the cycle after the edge.
  - A same-cycle read of the entry being written shows the old value.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start = 1 with count != 0: sel <= base, remaining <= count, go to SCAN.
  - start = 1 with count == 0: go to DONE directly; no word is presented.
  - start = 0: stay in IDLE; sel holds its last value.
- SCAN:
  - out_valid = 1 and busy = 1, both combinationally from state.
  - Handshake: a word transfers on an edge where out_valid && out_ready.
  - On transfer: sel <= sel + 1 mod 64 (63 wraps to 0); remaining <= remaining - 1.
  - If remaining == 1 at transfer, go to DONE.
  - Without out_ready: sel, remaining and state hold. Data may change under a held sel if the entry is written; the downstream sees the current value.
  - start is ignored in SCAN.
- DONE:
  - done = 1 for exactly one cycle, out_valid = 0, busy = 0.
  - Always returns to IDLE; start is ignored in DONE.
- Latency:
  - First word is valid the cycle after an accepted start.
  - Minimum run time is count + 1 cycles from start to done, with out_ready held high.
  - count = 64 visits every entry exactly once, starting at base.
- Reset mid-scan: aborts the run; no done pulse; bank cleared.
- count > 64 is illegal. Implementation saturates at 64; the bench checks the saturation.

Decomposition:
- Package bank64_pkg:
  - NREG = 64, SEL_W = 6, CNT_W = 7
  - scan_state_t enum {IDLE, SCAN, DONE}
- Sub-module regbank64: the 64 x size storage with write port and flat output.
- The scan FSM, sel counter and remaining counter stay in bank64_scan.

Test Plan:
- Write then readout: write entry i = i+100 for i = 0..63, then start base = 0, count = 64 with out_ready = 1 → sel steps 0..63 on consecutive cycles; selector output is 100..163; done pulses at cycle 65 after start.
- Wrap-around: base = 62, count = 4 → sel sequence 62, 63, 0, 1, then a done pulse; out_valid is high exactly 4 cycles.
- Back-pressure: base = 5, count = 3, out_ready pattern 1,0,0,1,1 → sel = 5, 6, 6, 6, 7; done only after the third transfer; start pulses during SCAN are ignored.
- Zero count and write-during-scan:
  - count = 0 → done the cycle after start, out_valid never high.
  - During a stalled scan at sel = 10, write entry 10 = 0xDEAD → regs_flat slice 10 reads 0xDEAD the next cycle, while sel stays 10.
- Reset mid-operation: assert reset during a count = 20 scan after 7 transfers → next cycle out_valid = 0, busy = 0, sel = 0, no done pulse, all regs_flat = 0; a new start then behaves normally.
